// File: rtl/ads1115_scan_sequencer.sv
// Round-robin ADS1115 single-ended scanner driving a byte-level I2C master.
// Define ADS_SCAN_OS_POLL_EN to replace the fixed conversion wait with OS-bit polling.
module ads1115_scan_sequencer #(
  parameter logic [6:0]  I2C_ADDR    = 7'b1001000,
  parameter logic [2:0]  PGA         = 3'b010,
  parameter logic [2:0]  DR          = 3'b100,
  parameter int unsigned WAIT_CYCLES = 400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  chan_mask,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_start,
  output logic        cmd_stop,
  output logic        cmd_read,
  output logic        cmd_nack,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_ack_err,
  output logic [15:0] data_out,
  output logic [1:0]  data_ch,
  output logic        data_valid,
  output logic        err,
  output logic        busy
);
  localparam logic [31:0] WAIT_LAST = 32'(WAIT_CYCLES - 1);
  localparam logic [7:0]  ADDR_WR   = {I2C_ADDR, 1'b0};
  localparam logic [7:0]  ADDR_RD   = {I2C_ADDR, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CFG_WR,
`ifdef ADS_SCAN_OS_POLL_EN
    S_POLL,
`else
    S_WAIT,
`endif
    S_PTR_WR,
    S_RD,
    S_STORE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  last_ch_q, last_ch_d;
  logic [1:0]  cur_ch_q, cur_ch_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        pend_q, pend_d;
  logic [7:0]  msb_q, msb_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] data_out_q, data_out_d;
  logic [1:0]  data_ch_q, data_ch_d;
  logic        data_valid_q, data_valid_d;
  logic        err_q, err_d;
  logic [1:0]  pick, idx;
  logic        found, rsp_ok, cont, is_cmd, abandon, hold;

`ifdef ADS_SCAN_OS_POLL_EN
  localparam logic [31:0] POLL_GAP_LAST = 32'd999;
  logic [31:0] tot_q, tot_d;
  logic        gap_q, gap_d;
  assign hold = gap_q;
`else
  assign hold = 1'b0;
`endif

  // Next enabled channel after the last one converted, wrapping 3 -> 0.
  always_comb begin
    pick  = last_ch_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_ch_q + 2'(i);
      if (!found && chan_mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_read  = 1'b0;
    cmd_nack  = 1'b0;
    cmd_wdata = '0;
    case (state_q)
      S_CFG_WR: begin
        case (step_q)
          2'd0:    begin cmd_start = 1'b1; cmd_wdata = ADDR_WR; end
          2'd1:    cmd_wdata = 8'h01;
          2'd2:    cmd_wdata = {1'b1, 1'b1, cur_ch_q, PGA, 1'b1};
          default: begin cmd_wdata = {DR, 5'b00011}; cmd_stop = 1'b1; end
        endcase
      end
      S_PTR_WR: begin
        if (step_q == 2'd0) begin
          cmd_start = 1'b1;
          cmd_wdata = ADDR_WR;
        end else begin
          cmd_wdata = 8'h00;
          cmd_stop  = 1'b1;
        end
      end
`ifdef ADS_SCAN_OS_POLL_EN
      S_RD, S_POLL: begin
`else
      S_RD: begin
`endif
        case (step_q)
          2'd0:    begin cmd_start = 1'b1; cmd_wdata = ADDR_RD; end
          2'd1:    cmd_read = 1'b1;
          default: begin cmd_read = 1'b1; cmd_nack = 1'b1; cmd_stop = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    last_ch_d    = last_ch_q;
    cur_ch_d     = cur_ch_q;
    cmd_valid_d  = cmd_valid_q;
    pend_d       = pend_q;
    msb_d        = msb_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_ch_d    = data_ch_q;
    data_valid_d = 1'b0;
    err_d        = 1'b0;
    abandon      = 1'b0;
`ifdef ADS_SCAN_OS_POLL_EN
    tot_d        = tot_q;
    gap_d        = gap_q;
`endif
    rsp_ok = pend_q && rsp_valid;
    cont   = enable && (chan_mask != '0);
    is_cmd = (state_q == S_CFG_WR) || (state_q == S_PTR_WR) || (state_q == S_RD)
`ifdef ADS_SCAN_OS_POLL_EN
             || (state_q == S_POLL)
`endif
             ;

    // A response in the handshake cycle is dropped: pend_q only rises after it.
    if (is_cmd && !hold) begin
      if (!cmd_valid_q && !pend_q) begin
        cmd_valid_d = 1'b1;
      end else if (cmd_valid_q && cmd_ready) begin
        cmd_valid_d = 1'b0;
        pend_d      = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: if (cont) state_d = S_SELECT;
      S_SELECT: begin
        if (found) begin
          cur_ch_d  = pick;
          last_ch_d = pick;
          state_d   = S_CFG_WR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CFG_WR: begin
        if (rsp_ok) begin
          pend_d = 1'b0;
          if (rsp_ack_err) begin
            abandon = 1'b1;
          end else if (step_q == 2'd3) begin
`ifdef ADS_SCAN_OS_POLL_EN
            state_d = S_POLL;
            tot_d   = '0;
            gap_d   = 1'b0;
`else
            state_d = S_WAIT;
`endif
            cnt_d = '0;
          end else begin
            step_d      = step_q + 2'd1;
            cmd_valid_d = 1'b1;
          end
        end
      end
`ifdef ADS_SCAN_OS_POLL_EN
      S_POLL: begin
        tot_d = tot_q + 32'd1;
        if (gap_q) begin
          if (tot_q >= WAIT_LAST) begin
            abandon = 1'b1;
          end else if (cnt_q == POLL_GAP_LAST) begin
            gap_d       = 1'b0;
            cnt_d       = '0;
            step_d      = '0;
            cmd_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else if (rsp_ok) begin
          pend_d = 1'b0;
          if (step_q == 2'd0) begin
            if (rsp_ack_err) abandon = 1'b1;
            else begin step_d = 2'd1; cmd_valid_d = 1'b1; end
          end else if (step_q == 2'd1) begin
            msb_d       = rsp_data;
            step_d      = 2'd2;
            cmd_valid_d = 1'b1;
          end else if (msb_q[7]) begin
            state_d = S_PTR_WR;
          end else begin
            gap_d = 1'b1;
            cnt_d = '0;
          end
        end
      end
`else
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_PTR_WR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`endif
      S_PTR_WR: begin
        if (rsp_ok) begin
          pend_d = 1'b0;
          if (rsp_ack_err) abandon = 1'b1;
          else if (step_q == 2'd1) state_d = S_RD;
          else begin step_d = 2'd1; cmd_valid_d = 1'b1; end
        end
      end
      S_RD: begin
        if (rsp_ok) begin
          pend_d = 1'b0;
          if (step_q == 2'd0) begin
            if (rsp_ack_err) abandon = 1'b1;
            else begin step_d = 2'd1; cmd_valid_d = 1'b1; end
          end else if (step_q == 2'd1) begin
            msb_d       = rsp_data;
            step_d      = 2'd2;
            cmd_valid_d = 1'b1;
          end else begin
            data_out_d   = {msb_q, rsp_data};
            data_ch_d    = cur_ch_q;
            data_valid_d = 1'b1;
            state_d      = S_STORE;
          end
        end
      end
      S_STORE: state_d = cont ? S_SELECT : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abandon) begin
      err_d       = 1'b1;
      pend_d      = 1'b0;
      cmd_valid_d = 1'b0;
      state_d     = cont ? S_SELECT : S_IDLE;
    end
    if (state_d != state_q) step_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      last_ch_q    <= 2'd3;
      cur_ch_q     <= '0;
      cmd_valid_q  <= 1'b0;
      pend_q       <= 1'b0;
      msb_q        <= '0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      data_ch_q    <= '0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef ADS_SCAN_OS_POLL_EN
      tot_q        <= '0;
      gap_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      last_ch_q    <= last_ch_d;
      cur_ch_q     <= cur_ch_d;
      cmd_valid_q  <= cmd_valid_d;
      pend_q       <= pend_d;
      msb_q        <= msb_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_ch_q    <= data_ch_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
`ifdef ADS_SCAN_OS_POLL_EN
      tot_q        <= tot_d;
      gap_q        <= gap_d;
`endif
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign data_out   = data_out_q;
  assign data_ch    = data_ch_q;
  assign data_valid = data_valid_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);
endmodule
